// File: rtl/fir_decim_mac_sequencer.sv
// Decimating FIR controller: circular sample window, shared MAC over all taps, valid/ready output.
// Define FIR_DECIM_SAT_EN to saturate the output instead of wrapping it.
module fir_decim_mac_sequencer #(
    parameter int DATA_WIDTH        = 16,
    parameter int COEFF_WIDTH       = 16,
    parameter int TAPS              = 17,
    parameter int DECIMATION_FACTOR = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [DATA_WIDTH-1:0]   in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [DATA_WIDTH-1:0]   out_data,
    input  logic                           coef_we,
    input  logic [$clog2(TAPS)-1:0]        coef_addr,
    input  logic signed [COEFF_WIDTH-1:0]  coef_data,
    output logic                           coef_err,
    output logic                           busy
);

    localparam int AW     = $clog2(TAPS);
    localparam int PW     = (DECIMATION_FACTOR > 1) ? $clog2(DECIMATION_FACTOR) : 1;
    localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;
    localparam int ACC_W  = PROD_W + AW;

    localparam logic [AW-1:0] LAST_TAP   = AW'(TAPS - 1);
    localparam logic [AW:0]   TAPS_X     = (AW + 1)'(TAPS);
    localparam logic [PW-1:0] LAST_PHASE = PW'(DECIMATION_FACTOR - 1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t                        state_q, state_d;
    logic signed [DATA_WIDTH-1:0]  window_q [TAPS];
    logic signed [DATA_WIDTH-1:0]  window_d [TAPS];
    logic signed [COEFF_WIDTH-1:0] coef_q   [TAPS];
    logic signed [COEFF_WIDTH-1:0] coef_d   [TAPS];
    logic [AW-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                 base_q, base_d;
    logic [AW-1:0]                 k_q, k_d;
    logic [PW-1:0]                 phase_q, phase_d;
    logic signed [ACC_W-1:0]       acc_q, acc_d;
    logic                          out_valid_q, out_valid_d;
    logic signed [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic                          coef_err_q, coef_err_d;

    logic [AW:0]                   tap_sum;
    logic [AW-1:0]                 tap_idx;
    logic signed [PROD_W-1:0]      prod;
    logic signed [ACC_W-1:0]       prod_ext;
    logic signed [ACC_W-1:0]       shifted;
    logic signed [DATA_WIDTH-1:0]  result;

    // Window index of tap k: (base - k) mod TAPS, kept non-negative by adding TAPS first.
    always_comb begin
        tap_sum  = {1'b0, base_q} + TAPS_X - {1'b0, k_q};
        tap_idx  = (tap_sum >= TAPS_X) ? AW'(tap_sum - TAPS_X) : AW'(tap_sum);
        prod     = window_q[tap_idx] * coef_q[k_q];
        prod_ext = $signed({{AW{prod[PROD_W-1]}}, prod});
        shifted  = acc_q >>> COEFF_WIDTH;
    end

`ifdef FIR_DECIM_SAT_EN
    localparam logic signed [ACC_W-1:0] RES_MAX =
        {{(ACC_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] RES_MIN =
        {{(ACC_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    always_comb begin
        if (shifted > RES_MAX) begin
            result = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
        end else if (shifted < RES_MIN) begin
            result = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
        end else begin
            result = DATA_WIDTH'(shifted);
        end
    end
`else
    always_comb begin
        result = DATA_WIDTH'(shifted);
    end
`endif

    always_comb begin
        state_d     = state_q;
        window_d    = window_q;
        coef_d      = coef_q;
        wr_ptr_d    = wr_ptr_q;
        base_d      = base_q;
        k_d         = k_q;
        phase_d     = phase_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        coef_err_d  = 1'b0;

        if (clear) begin
            window_d    = '{default: '0};
            wr_ptr_d    = '0;
            phase_d     = '0;
            acc_d       = '0;
            k_d         = '0;
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
        end else begin
            if (coef_we) begin
                if (state_q == S_IDLE && {1'b0, coef_addr} < TAPS_X) begin
                    coef_d[coef_addr] = coef_data;
                end else begin
                    coef_err_d = 1'b1;
                end
            end

            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        window_d[wr_ptr_q] = in_data;
                        wr_ptr_d = (wr_ptr_q == LAST_TAP) ? '0 : wr_ptr_q + 1'b1;
                        if (phase_q == LAST_PHASE) begin
                            phase_d = '0;
                            base_d  = wr_ptr_q;
                            acc_d   = '0;
                            k_d     = '0;
                            state_d = S_MAC;
                        end else begin
                            phase_d = phase_q + 1'b1;
                        end
                    end
                end
                S_MAC: begin
                    acc_d = acc_q + prod_ext;
                    k_d   = k_q + 1'b1;
                    if (k_q == LAST_TAP) begin
                        state_d = S_OUT;
                    end
                end
                S_OUT: begin
                    // First OUT cycle registers the finished accumulator; handshake follows.
                    if (!out_valid_q) begin
                        out_valid_d = 1'b1;
                        out_data_d  = result;
                    end else if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            window_q    <= '{default: '0};
            coef_q      <= '{default: '0};
            wr_ptr_q    <= '0;
            base_q      <= '0;
            k_q         <= '0;
            phase_q     <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            coef_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            window_q    <= window_d;
            coef_q      <= coef_d;
            wr_ptr_q    <= wr_ptr_d;
            base_q      <= base_d;
            k_q         <= k_d;
            phase_q     <= phase_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            coef_err_q  <= coef_err_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign coef_err  = coef_err_q;

endmodule

// File: tb/tb_fir_decim_mac_sequencer.sv
// Directed bench for fir_decim_mac_sequencer with hand-computed expected outputs.
module tb_fir_decim_mac_sequencer;

    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int TAPS = 17;
    localparam int AW   = 5;
    localparam int LAT  = TAPS + 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 clear = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] in_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [DW-1:0] out_data;
    logic                 coef_we = 1'b0;
    logic [AW-1:0]        coef_addr = '0;
    logic signed [CW-1:0] coef_data = '0;
    logic                 coef_err;
    logic                 busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fir_decim_mac_sequencer #(
        .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .TAPS(TAPS), .DECIMATION_FACTOR(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_err(coef_err), .busy(busy)
    );

    task automatic do_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic write_coef(input int a, input int v);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = AW'(a); coef_data = CW'(v);
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    task automatic fill_coefs(input int v);
        for (int k = 0; k < TAPS; k++) write_coef(k, v);
    endtask

    // Offers one sample and returns just after the edge that accepts it.
    task automatic send_sample(input int v);
        @(negedge clk);
        in_valid = 1'b1; in_data = DW'(v);
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                @(posedge clk);
                break;
            end
            @(negedge clk);
        end
        #1 in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid; n counts clock edges waited. Consumes it if out_ready.
    task automatic get_out(output logic signed [DW-1:0] d, output int n);
        n = 0;
        d = 'x;
        for (int i = 0; i < 100; i++) begin
            if (out_valid === 1'b1) begin
                d = out_data;
                break;
            end
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_data !== '0)    begin n_fail++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
        n_checks++; if (coef_err !== 1'b0)  begin n_fail++; $display("FAIL reset_coef_err: got %b want 0", coef_err); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_impulse();
        int exp_v [5] = '{4, 8, 12, 16, 0};
        logic signed [DW-1:0] d;
        int n;
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, (k + 1) * 256);
        for (int i = 0; i < 20; i++) begin
            send_sample((i == 0) ? 256 : 0);
            if (i % 4 == 3) begin
                get_out(d, n);
                n_checks++;
                if (int'(d) !== exp_v[i/4]) begin
                    n_fail++; $display("FAIL impulse_out[%0d]: got %0d want %0d", i / 4, d, exp_v[i/4]);
                end
            end
        end
    endtask

    task automatic test_dc_gain();
        int exp_v [6] = '{4096, 8192, 12288, 16384, 17408, 17408};
        logic signed [DW-1:0] d;
        int n;
        do_reset();
        fill_coefs(16384);
        for (int i = 0; i < 24; i++) begin
            send_sample(4096);
            if (i % 4 == 3) begin
                get_out(d, n);
                n_checks++;
                if (int'(d) !== exp_v[i/4]) begin
                    n_fail++; $display("FAIL dc_out[%0d]: got %0d want %0d", i / 4, d, exp_v[i/4]);
                end
                n_checks++;
                if (n !== LAT) begin
                    n_fail++; $display("FAIL dc_latency[%0d]: got %0d want %0d", i / 4, n, LAT);
                end
            end
        end
    endtask

    task automatic test_saturation();
`ifdef FIR_DECIM_SAT_EN
        int exp_v [5] = '{32767, 32767, 32767, 32767, 32767};
`else
        int exp_v [5] = '{-4, -8, -12, -16, 16367};
`endif
        logic signed [DW-1:0] d;
        int n;
        do_reset();
        fill_coefs(32767);
        for (int i = 0; i < 20; i++) begin
            send_sample(32767);
            if (i % 4 == 3) begin
                get_out(d, n);
                n_checks++;
                if (int'(d) !== exp_v[i/4]) begin
                    n_fail++; $display("FAIL sat_out[%0d]: got %0d want %0d", i / 4, d, exp_v[i/4]);
                end
            end
        end
    endtask

    task automatic test_negative_floor();
        logic signed [DW-1:0] d;
        int n;
        do_reset();
        write_coef(0, 1);
        for (int i = 0; i < 4; i++) send_sample(-5);
        get_out(d, n);
        n_checks++; if (int'(d) !== -1) begin n_fail++; $display("FAIL floor_out: got %0d want -1", d); end
    endtask

    task automatic test_backpressure();
        logic signed [DW-1:0] d;
        int  n;
        bit  seen;
        do_reset();
        fill_coefs(16384);
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_sample(i * 400);
        @(negedge clk);
        in_valid = 1'b1; in_data = DW'(2000);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid === 1'b1) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL bp_out_valid: got 0 want 1"); end
        for (int c = 0; c < 10; c++) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", c, out_valid); end
            n_checks++; if (int'(out_data) !== 1000) begin n_fail++; $display("FAIL bp_hold_data[%0d]: got %0d want 1000", c, out_data); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_handshake: got %b want 0", out_valid); end
        send_sample(2000);
        for (int i = 6; i <= 8; i++) send_sample(i * 400);
        get_out(d, n);
        n_checks++; if (int'(d) !== 3600) begin n_fail++; $display("FAIL bp_second_out: got %0d want 3600", d); end
    endtask

    task automatic test_config_guard();
        logic signed [DW-1:0] d;
        int n;
        do_reset();
        fill_coefs(16384);
        n_checks++; if (coef_err !== 1'b0) begin n_fail++; $display("FAIL guard_valid_write_err: got %b want 0", coef_err); end
        for (int i = 0; i < 4; i++) send_sample(4096);
        repeat (5) @(posedge clk);
        #1;
        coef_we = 1'b1; coef_addr = '0; coef_data = '0;
        @(posedge clk); #1;
        coef_we = 1'b0;
        n_checks++; if (coef_err !== 1'b1) begin n_fail++; $display("FAIL guard_mac_err: got %b want 1", coef_err); end
        n_checks++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL guard_busy: got %b want 1", busy); end
        @(posedge clk); #1;
        n_checks++; if (coef_err !== 1'b0) begin n_fail++; $display("FAIL guard_mac_err_pulse: got %b want 0", coef_err); end
        get_out(d, n);
        n_checks++; if (int'(d) !== 4096) begin n_fail++; $display("FAIL guard_out1: got %0d want 4096", d); end
        for (int i = 0; i < 4; i++) send_sample(4096);
        get_out(d, n);
        n_checks++; if (int'(d) !== 8192) begin n_fail++; $display("FAIL guard_out2: got %0d want 8192", d); end
        write_coef(17, 0);
        n_checks++; if (coef_err !== 1'b1) begin n_fail++; $display("FAIL guard_addr_err: got %b want 1", coef_err); end
        @(posedge clk); #1;
        n_checks++; if (coef_err !== 1'b0) begin n_fail++; $display("FAIL guard_addr_err_pulse: got %b want 0", coef_err); end
        for (int i = 0; i < 4; i++) send_sample(4096);
        get_out(d, n);
        n_checks++; if (int'(d) !== 12288) begin n_fail++; $display("FAIL guard_out3: got %0d want 12288", d); end
    endtask

    task automatic test_clear();
        logic signed [DW-1:0] d;
        int n;
        bit seen;
        do_reset();
        fill_coefs(16384);
        for (int i = 0; i < 4; i++) send_sample(4096);
        repeat (8) @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL clear_in_ready: got %b want 1", in_ready); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL clear_busy: got %b want 0", busy); end
        seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++; if (seen) begin n_fail++; $display("FAIL clear_no_output: got 1 want 0"); end
        for (int i = 0; i < 4; i++) send_sample(1000);
        get_out(d, n);
        n_checks++; if (int'(d) !== 1000) begin n_fail++; $display("FAIL clear_next_out: got %0d want 1000", d); end
        n_checks++; if (n !== LAT)        begin n_fail++; $display("FAIL clear_latency: got %0d want %0d", n, LAT); end
    endtask

    task automatic test_reset_mid_out();
        bit seen;
        do_reset();
        fill_coefs(16384);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_sample(4096);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid === 1'b1) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL rst_mid_reach_out: got 0 want 1"); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_data !== '0)    begin n_fail++; $display("FAIL rst_mid_out_data: got %0d want 0", out_data); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_dc_gain();
        test_saturation();
        test_negative_floor();
        test_backpressure();
        test_config_guard();
        test_clear();
        test_reset_mid_out();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
